// File: rtl/exe_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// exe_fwd_ctrl
//
// Hazard and forwarding controller for a five-stage pipeline. It tracks the
// destination registers of the three instructions downstream of ID (EXE, MEM,
// WB) in a small scoreboard and, for the instruction currently in ID, decides:
//   - whether it must stall (load-use with forwarding, any RAW without it),
//   - which operand source the EXE stage muxes should pick once it issues,
//   - whether the IF/ID contents must be killed because of a taken branch.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   fwd_en              1 = forward from EXE/MEM and WB, 0 = stall on all RAW
//   id_valid            ID holds a real instruction
//   id_src1, id_src2    source register numbers of the ID instruction
//   id_two_src          id_src2 is a real operand
//   id_dest             destination register of the ID instruction
//   id_wb_en            ID instruction writes id_dest
//   id_mem_r_en         ID instruction is a load
//   branch_taken        the EXE instruction is a taken branch
//   sel_src1, sel_src2  registered EXE operand selects (0 RF, 1 EXE/MEM, 2 WB)
//   stall               combinational; freeze PC/IF-ID, issue a bubble
//   flush               combinational; kill IF/ID
//   stall_cnt           saturating count of stall cycles
// ---------------------------------------------------------------------------
module exe_fwd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fwd_en,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic [3:0]  id_dest,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic        branch_taken,
    output logic [1:0]  sel_src1,
    output logic [1:0]  sel_src2,
    output logic        stall,
    output logic        flush,
    output logic [15:0] stall_cnt
);

    // One scoreboard entry per downstream stage.
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
    } slot_t;

    // Operand mux encodings; the fourth code is never produced.
    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_EXE = 2'd1,
        SEL_WB  = 2'd2
    } sel_e;

    localparam logic [3:0]  PC_REG   = 4'd15;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam slot_t       BUBBLE   = '0;

    slot_t exe_slot;
    slot_t mem_slot;
    slot_t wb_slot;
    slot_t issue_entry;

    logic  used1;
    logic  used2;
    logic  exe_hit;
    logic  mem_hit;
    logic  load_use;
    logic  raw_no_fwd;
    logic  stall_need;
    logic  issue_valid;
    sel_e  sel1_next;
    sel_e  sel2_next;

    // The WB entry is kept so the scoreboard mirrors the whole back end, but
    // nothing reads it: the register file writes before it is read, so the
    // WB-stage producer never causes a hazard. This sink keeps it referenced.
    logic  wb_slot_unused_sink;
    assign wb_slot_unused_sink = ^wb_slot;

    // A slot produces register r only if it is a live writer. Writes to the
    // PC are handled by the branch path, never by forwarding, so r15 as a
    // destination is treated as if the write enable were clear.
    function automatic logic slot_match(input slot_t s, input logic [3:0] r);
        return s.valid & s.wb_en & (s.dest != PC_REG) & (s.dest == r);
    endfunction

    // The EXE producer is younger than the MEM one, so its result wins.
    function automatic sel_e fwd_select(input slot_t e, input slot_t m,
                                        input logic [3:0] r);
        sel_e s;
        if (slot_match(e, r))
            s = SEL_EXE;
        else if (slot_match(m, r))
            s = SEL_WB;
        else
            s = SEL_RF;
        return s;
    endfunction

    // Hazard detection. src2 only counts when the instruction really reads
    // it; a stall is never raised while the ID instruction is being flushed.
    always_comb begin
        used1      = id_valid;
        used2      = id_valid & id_two_src;

        exe_hit    = (used1 & slot_match(exe_slot, id_src1)) |
                     (used2 & slot_match(exe_slot, id_src2));
        mem_hit    = (used1 & slot_match(mem_slot, id_src1)) |
                     (used2 & slot_match(mem_slot, id_src2));

        load_use   = fwd_en & exe_slot.mem_r_en & exe_hit;
        raw_no_fwd = ~fwd_en & (exe_hit | mem_hit);
        stall_need = load_use | raw_no_fwd;
    end

    assign flush = branch_taken & exe_slot.valid;
    assign stall = stall_need & ~flush;

    // What enters EXE on the next edge: the ID fields, or a bubble when there
    // is nothing to issue, the instruction is held back, or it is killed.
    always_comb begin
        issue_valid          = id_valid & ~stall & ~flush;
        issue_entry          = BUBBLE;
        if (issue_valid) begin
            issue_entry.valid    = 1'b1;
            issue_entry.dest     = id_dest;
            issue_entry.wb_en    = id_wb_en;
            issue_entry.mem_r_en = id_mem_r_en;
        end
    end

    // Operand selects are decided in ID against the producers that will sit
    // one stage ahead once this instruction reaches EXE: today's EXE becomes
    // MEM (ALU result path) and today's MEM becomes WB.
    always_comb begin
        sel1_next = SEL_RF;
        sel2_next = SEL_RF;
        if (issue_valid && fwd_en) begin
            if (used1)
                sel1_next = fwd_select(exe_slot, mem_slot, id_src1);
            if (used2)
                sel2_next = fwd_select(exe_slot, mem_slot, id_src2);
        end
    end

    // Scoreboard shift. A taken branch also retires the EXE entry as a
    // bubble so that MEM is empty on the cycle after the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_slot <= BUBBLE;
            mem_slot <= BUBBLE;
            wb_slot  <= BUBBLE;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= flush ? BUBBLE : exe_slot;
            exe_slot <= issue_entry;
        end
    end

    // Operand selects travel with the instruction into EXE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_src1 <= SEL_RF;
            sel_src2 <= SEL_RF;
        end else begin
            sel_src1 <= sel1_next;
            sel_src2 <= sel2_next;
        end
    end

    // Stall-cycle counter; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
